// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the word PC, issues one instruction fetch at a time and holds the word until decode retires it
module fetch_sequencer #(
    parameter int WIDTH = 30,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] TRAP_ADDR = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] instr_npc,
    input  logic             instr_ready,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             trap,
    input  logic             halt,
    output logic             halted,
    output logic [31:0]      retired
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;
    state_t state;
    logic [WIDTH-1:0] pc, pc_next;
    always_comb pc_next = trap ? TRAP_ADDR : br_taken ? br_target : pc + 1'b1;
    // pc only moves on retire, so it is the stable fetch address throughout FETCH
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_npc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    instr       <= imem_rdata;
                    instr_pc    <= pc;
                    instr_npc   <= pc + 1'b1;
                    instr_valid <= 1'b1;
                    imem_req    <= 1'b0;
                    state       <= HOLD;
                end
                HOLD: if (instr_ready) begin
                    pc          <= pc_next;
                    retired     <= retired + 1'b1;
                    instr_valid <= 1'b0;
                    state       <= halt ? HALTED : FETCH;
                    imem_req    <= !halt;
                    halted      <= halt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench, fetched words queued on ack and checked at retire
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst, imem_ack, instr_ready, br_taken, trap, halt;
    logic        imem_req, instr_valid, halted;
    logic [29:0] imem_addr, instr_pc, instr_npc, br_target;
    logic [31:0] imem_rdata, instr, retired;
    typedef struct {logic [31:0] w; logic [29:0] pc; logic [29:0] npc;} item_t;
    item_t sb[$];
    int total = 0, bad = 0;
    logic [29:0] exp_pc;
    logic [31:0] exp_ret;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_npc(instr_npc),
        .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
        .trap(trap), .halt(halt), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A3C_0000;
    endfunction

    task automatic clear_inputs();
        imem_ack = 0; instr_ready = 0; br_taken = 0; trap = 0; halt = 0;
        br_target = '0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) step();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
        check("rst_instr", {instr, instr_pc}, 0);
        check("rst_npc", instr_npc, 0);
        rst = 0;
        exp_pc = '0;
        exp_ret = '0;
        sb.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", imem_req, 1);
    endtask

    task automatic fetch_one(input int stall, input logic br, input logic [29:0] tgt,
                             input logic tr, input logic hl, input int rwait);
        item_t it;
        wait_req();
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_req", {imem_req, instr_valid}, 2'b10);
            check("stall_addr", imem_addr, exp_pc);
        end
        imem_ack = 1;
        imem_rdata = word(imem_addr);
        sb.push_back('{word(exp_pc), exp_pc, exp_pc + 30'd1});
        step();
        imem_ack = 0;
        check("valid_after_ack", {instr_valid, imem_req}, 2'b10);
        for (int i = 0; i < rwait; i++) begin
            step();
            check("valid_held", instr_valid, 1);
        end
        instr_ready = 1; br_taken = br; br_target = tgt; trap = tr; halt = hl;
        if (sb.size() == 0) check("sb_empty", 0, 1);
        else begin
            it = sb.pop_front();
            check("instr", instr, it.w);
            check("instr_pc", instr_pc, it.pc);
            check("instr_npc", instr_npc, it.npc);
        end
        step();
        clear_inputs();
        exp_pc = tr ? 30'd1 : br ? tgt : exp_pc + 30'd1;
        exp_ret++;
        check("retired", retired, exp_ret);
        check("valid_cleared", instr_valid, 0);
        if (hl) check("halt_state", {halted, imem_req}, 2'b10);
        else begin
            check("next_req", {halted, imem_req}, 2'b01);
            check("next_addr", imem_addr, exp_pc);
        end
    endtask

    initial begin
        step();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_one(0, 0, '0, 0, 0, 0);
        check("retired4", retired, 4);
        fetch_one(0, 1, 30'h100, 0, 0, 1);
        fetch_one(1, 1, 30'h20, 1, 0, 0);
        fetch_one(0, 1, 30'd7, 0, 0, 2);
        fetch_one(5, 0, '0, 0, 0, 0);
        fetch_one(0, 1, 30'h3FFF_FFFF, 0, 0, 0);
        fetch_one(0, 0, '0, 0, 0, 0);
        check("wrap_addr", imem_addr, 0);
        fetch_one(2, 0, '0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            imem_ack = i[0]; imem_rdata = 32'hDEAD_BEEF;
            instr_ready = 1; trap = 1; br_taken = 1;
            step();
            check("halted_idle", {halted, imem_req, instr_valid}, 3'b100);
        end
        check("halted_retired", retired, exp_ret);
        do_reset();
        fetch_one(0, 0, '0, 0, 0, 0);
        do_reset();
        wait_req();
        imem_ack = 1; imem_rdata = 32'h1234_5678; rst = 1;
        step();
        check("rst_ack_valid", {instr_valid, imem_req}, 0);
        check("rst_ack_retired", retired, 0);
        rst = 0; imem_ack = 0;
        fetch_one(0, 0, '0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end
endmodule
